// File: rtl/cache_pkg.sv
// Shared encodings for the L1 request path: sequencer states, request-status bit indices,
// MESI block states, and the snoop request and response codes.
// Pure definitions; no timing or flow control of its own.
package cache_pkg;

    // Request sequencer state. Codes 6 and 7 are unused and recover to REQ_IDLE.
    typedef enum logic [2:0] {
        REQ_IDLE      = 3'd0,
        REQ_LOOKUP    = 3'd1,
        REQ_SDREQ     = 3'd2,
        REQ_WAIT      = 3'd3,
        REQ_RSP_CURSP = 3'd4,
        REQ_ERR       = 3'd5
    } req_st_e;

    // Bit positions inside the one-hot req_status vector.
    localparam int RS_READ_HIT   = 0;
    localparam int RS_WRITE_HIT  = 1;
    localparam int RS_READ_MISS  = 2;
    localparam int RS_WRITE_MISS = 3;

    // MESI block states.
    localparam logic [2:0] INVALID   = 3'd0;
    localparam logic [2:0] SHARED    = 3'd1;
    localparam logic [2:0] EXCLUSIVE = 3'd2;
    localparam logic [2:0] MODIFIED  = 3'd3;

    // Downstream snoop request types.
    localparam logic [2:0] SDREQ_NONE = 3'd0;
    localparam logic [2:0] SDREQ_READ = 3'd1;
    localparam logic [2:0] SDREQ_RFO  = 3'd2;
    localparam logic [2:0] SDREQ_INV  = 3'd3;

    // Downstream response types.
    localparam logic [2:0] SURSP_NONE  = 3'd0;
    localparam logic [2:0] SURSP_SNOOP = 3'd1;
    localparam logic [2:0] SURSP_FETCH = 3'd2;

endpackage

// File: rtl/l1_req_timer.sv
// Timeout counter for the bus-response wait: cleared by load, counts up while en is high.
// Latency: expire is combinational from the count and is high when count == TIMEOUT_CYC-1.
// Backpressure: none; the count saturates at TIMEOUT_CYC and never wraps.
// Ports: clk, rst_n (sync, active low), load (clear), en (count), expire (deadline reached).
module l1_req_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_EXP = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expire = (cnt_q == CNT_EXP);

endmodule

// File: rtl/l1_req_seq.sv
// Sequencer for one outstanding CPU request: lookup, optional snoop request, wait, state write, CPU response.
// Latency: a hit responds 2 cycles after accept; a miss adds the snoop handshake and the bus wait.
// Backpressure: cureq_ready only in REQ_IDLE; sdreq and cursp are held until accepted; timeout bounds the wait.
// Ports: CPU request (cureq_*), lookup result (lkup_*), FSM interface (req_status, req_curSt, blk_curSt,
//        sursp_q, fsm_*), snoop request (sdreq_*), bus response (sursp_*), block-state write (blk_wr_*),
//        CPU response (cursp_*).
module l1_req_seq
    import cache_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cureq_valid,
    output logic              cureq_ready,
    input  logic              cureq_wr,
    input  logic [ADDR_W-1:0] cureq_addr,
    input  logic              lkup_hit,
    input  logic [2:0]        lkup_blkSt,
    output logic [3:0]        req_status,
    output logic [2:0]        req_curSt,
    output logic [2:0]        blk_curSt,
    output logic [2:0]        sursp_q,
    input  logic [2:0]        fsm_init_sdreq,
    input  logic [2:0]        fsm_blk_nxtSt,
    output logic              sdreq_valid,
    input  logic              sdreq_ready,
    output logic [2:0]        sdreq_op,
    output logic [ADDR_W-1:0] sdreq_addr,
    input  logic              sursp_valid,
    input  logic [2:0]        sursp_rsp,
    output logic              blk_wr_en,
    output logic [2:0]        blk_wr_st,
    output logic [ADDR_W-1:0] blk_wr_addr,
    output logic              cursp_valid,
    input  logic              cursp_ready,
    output logic              cursp_err
);

    req_st_e           state_q, state_d;
    logic              wr_q;
    logic              hit_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        op_q;
    logic              first_q;     // first cycle after any state change
    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_expire;

    l1_req_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    assign tmr_load = (state_q == REQ_SDREQ) && sdreq_ready;
    assign tmr_en   = (state_q == REQ_WAIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ_IDLE:      if (cureq_valid) state_d = REQ_LOOKUP;
            // A write hit on a SHARED line still needs an invalidate on the bus.
            REQ_LOOKUP:    state_d = (lkup_hit && !(wr_q && (lkup_blkSt == SHARED)))
                                     ? REQ_RSP_CURSP : REQ_SDREQ;
            REQ_SDREQ:     if (sdreq_ready) state_d = REQ_WAIT;
            // A response arriving on the expiry cycle still completes normally.
            REQ_WAIT:      if (sursp_valid)     state_d = REQ_RSP_CURSP;
                           else if (tmr_expire) state_d = REQ_ERR;
            REQ_RSP_CURSP: if (cursp_ready) state_d = REQ_IDLE;
            REQ_ERR:       if (cursp_ready) state_d = REQ_IDLE;
            default:       state_d = REQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= REQ_IDLE;
            first_q   <= 1'b0;
            wr_q      <= 1'b0;
            hit_q     <= 1'b0;
            addr_q    <= '0;
            op_q      <= SDREQ_NONE;
            blk_curSt <= INVALID;
            sursp_q   <= SURSP_NONE;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
            if ((state_q == REQ_IDLE) && cureq_valid) begin
                wr_q    <= cureq_wr;
                addr_q  <= cureq_addr;
                sursp_q <= SURSP_NONE;
            end
            if (state_q == REQ_LOOKUP) begin
                hit_q     <= lkup_hit;
                blk_curSt <= lkup_blkSt;
            end
            if (state_q == REQ_SDREQ) begin
                op_q <= sdreq_op;
            end
            if ((state_q == REQ_WAIT) && sursp_valid) begin
                sursp_q <= sursp_rsp;
            end
        end
    end

    // Status is meaningful only once the lookup result has been captured.
    always_comb begin
        req_status = '0;
        if ((state_q == REQ_SDREQ) || (state_q == REQ_WAIT) ||
            (state_q == REQ_RSP_CURSP) || (state_q == REQ_ERR)) begin
            case ({wr_q, hit_q})
                2'b01:   req_status[RS_READ_HIT]   = 1'b1;
                2'b11:   req_status[RS_WRITE_HIT]  = 1'b1;
                2'b00:   req_status[RS_READ_MISS]  = 1'b1;
                default: req_status[RS_WRITE_MISS] = 1'b1;
            endcase
        end
    end

    assign req_curSt   = state_q;
    assign cureq_ready = (state_q == REQ_IDLE);

    // The FSM's choice passes straight through on the first SDREQ cycle, then the captured copy
    // is held so the op cannot change while the request waits for acceptance.
    assign sdreq_valid = (state_q == REQ_SDREQ);
    assign sdreq_op    = (state_q != REQ_SDREQ) ? SDREQ_NONE :
                         (first_q ? fsm_init_sdreq : op_q);
    assign sdreq_addr  = addr_q;

    assign blk_wr_en   = (state_q == REQ_RSP_CURSP) && first_q;
    assign blk_wr_st   = blk_wr_en ? fsm_blk_nxtSt : INVALID;
    assign blk_wr_addr = addr_q;

    assign cursp_valid = (state_q == REQ_RSP_CURSP) || (state_q == REQ_ERR);
    assign cursp_err   = (state_q == REQ_ERR);

endmodule

// File: tb/tb_l1_req_seq.sv
module tb_l1_req_seq;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cureq_valid, cureq_valid_t;
    logic        cureq_wr;
    logic [31:0] cureq_addr;
    logic        lkup_hit;
    logic [2:0]  lkup_blkSt;
    logic        sdreq_ready;
    logic        sursp_valid;
    logic [2:0]  sursp_rsp;
    logic        cursp_ready;
    logic        corrupt;

    // main instance (default timeout)
    logic        cureq_ready, sdreq_valid, blk_wr_en, cursp_valid, cursp_err;
    logic [3:0]  req_status;
    logic [2:0]  req_curSt, blk_curSt, sursp_q, sdreq_op, blk_wr_st;
    logic [2:0]  fsm_init_sdreq, fsm_blk_nxtSt;
    logic [31:0] sdreq_addr, blk_wr_addr;

    // short-timeout instance
    logic        t_cureq_ready, t_sdreq_valid, t_blk_wr_en, t_cursp_valid, t_cursp_err;
    logic [3:0]  t_req_status;
    logic [2:0]  t_req_curSt, t_blk_curSt, t_sursp_q, t_sdreq_op, t_blk_wr_st;
    logic [2:0]  t_fsm_init_sdreq, t_fsm_blk_nxtSt;
    logic [31:0] t_sdreq_addr, t_blk_wr_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Reference model of the external request-control FSM: {sdreq type, next block state}.
    function automatic logic [5:0] fsm_model(input logic [3:0] st, input logic [2:0] blk,
                                             input logic [2:0] rsp);
        logic [2:0] sd;
        logic [2:0] nx;
        sd = SDREQ_NONE;
        nx = blk;
        if (st[RS_READ_MISS]) begin
            sd = SDREQ_READ;
            nx = (rsp == SURSP_SNOOP) ? SHARED : EXCLUSIVE;
        end else if (st[RS_WRITE_MISS]) begin
            sd = SDREQ_RFO;
            nx = MODIFIED;
        end else if (st[RS_WRITE_HIT]) begin
            sd = (blk == SHARED) ? SDREQ_INV : SDREQ_NONE;
            nx = MODIFIED;
        end
        return {sd, nx};
    endfunction

    always_comb begin
        logic [5:0] m;
        m = fsm_model(req_status, blk_curSt, sursp_q);
        // corrupt changes the live request type so a non-held sdreq_op shows up
        fsm_init_sdreq = corrupt ? SDREQ_NONE : m[5:3];
        fsm_blk_nxtSt  = m[2:0];
    end

    always_comb begin
        logic [5:0] m;
        m = fsm_model(t_req_status, t_blk_curSt, t_sursp_q);
        t_fsm_init_sdreq = m[5:3];
        t_fsm_blk_nxtSt  = m[2:0];
    end

    l1_req_seq #(.ADDR_W(32), .TIMEOUT_CYC(255)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cureq_valid(cureq_valid), .cureq_ready(cureq_ready), .cureq_wr(cureq_wr),
        .cureq_addr(cureq_addr), .lkup_hit(lkup_hit), .lkup_blkSt(lkup_blkSt),
        .req_status(req_status), .req_curSt(req_curSt), .blk_curSt(blk_curSt),
        .sursp_q(sursp_q), .fsm_init_sdreq(fsm_init_sdreq), .fsm_blk_nxtSt(fsm_blk_nxtSt),
        .sdreq_valid(sdreq_valid), .sdreq_ready(sdreq_ready), .sdreq_op(sdreq_op),
        .sdreq_addr(sdreq_addr), .sursp_valid(sursp_valid), .sursp_rsp(sursp_rsp),
        .blk_wr_en(blk_wr_en), .blk_wr_st(blk_wr_st), .blk_wr_addr(blk_wr_addr),
        .cursp_valid(cursp_valid), .cursp_ready(cursp_ready), .cursp_err(cursp_err)
    );

    l1_req_seq #(.ADDR_W(32), .TIMEOUT_CYC(4)) u_dut_to (
        .clk(clk), .rst_n(rst_n),
        .cureq_valid(cureq_valid_t), .cureq_ready(t_cureq_ready), .cureq_wr(cureq_wr),
        .cureq_addr(cureq_addr), .lkup_hit(lkup_hit), .lkup_blkSt(lkup_blkSt),
        .req_status(t_req_status), .req_curSt(t_req_curSt), .blk_curSt(t_blk_curSt),
        .sursp_q(t_sursp_q), .fsm_init_sdreq(t_fsm_init_sdreq), .fsm_blk_nxtSt(t_fsm_blk_nxtSt),
        .sdreq_valid(t_sdreq_valid), .sdreq_ready(sdreq_ready), .sdreq_op(t_sdreq_op),
        .sdreq_addr(t_sdreq_addr), .sursp_valid(sursp_valid), .sursp_rsp(sursp_rsp),
        .blk_wr_en(t_blk_wr_en), .blk_wr_st(t_blk_wr_st), .blk_wr_addr(t_blk_wr_addr),
        .cursp_valid(t_cursp_valid), .cursp_ready(cursp_ready), .cursp_err(t_cursp_err)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if ({cureq_ready, req_curSt, sdreq_valid, blk_wr_en, cursp_valid, cursp_err} !== 8'b1_000_0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 10000000",
                     {cureq_ready, req_curSt, sdreq_valid, blk_wr_en, cursp_valid, cursp_err});
        end
        n_tests++;
        if ({req_status, blk_curSt, sursp_q, sdreq_op, blk_wr_st} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0000",
                     {req_status, blk_curSt, sursp_q, sdreq_op, blk_wr_st});
        end
        n_tests++;
        if ({sdreq_addr, blk_wr_addr} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h/%h expected 0/0", sdreq_addr, blk_wr_addr);
        end
        n_tests++;
        if ({t_cureq_ready, t_req_curSt, t_cursp_valid} !== 5'b1_000_0) begin
            n_fail++;
            $display("FAIL reset_to_inst: got %b expected 10000", {t_cureq_ready, t_req_curSt, t_cursp_valid});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Hit that completes without a snoop request; cursp_ready held high from the start.
    task automatic test_hit(input string nm, input logic wr, input logic [31:0] addr,
                            input logic [2:0] blk, input logic [2:0] exp_nxt, input logic [3:0] exp_status);
        cureq_valid = 1'b1; cureq_wr = wr; cureq_addr = addr; cursp_ready = 1'b1;
        @(negedge clk);                                         // cycle 1: accept
        n_tests++;
        if (cureq_ready !== 1'b1) begin n_fail++; $display("FAIL %s_accept: got %b expected 1", nm, cureq_ready); end
        @(posedge clk); #1;
        cureq_valid = 1'b0; lkup_hit = 1'b1; lkup_blkSt = blk;
        @(negedge clk);                                         // cycle 2: lookup
        n_tests++;
        if (req_curSt !== REQ_LOOKUP || cursp_valid !== 1'b0 || cureq_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s_lookup: got st=%0d vld=%b rdy=%b expected st=1 vld=0 rdy=0",
                               nm, req_curSt, cursp_valid, cureq_ready);
        end
        @(posedge clk); #1;
        lkup_hit = 1'b0; lkup_blkSt = INVALID;
        @(negedge clk);                                         // cycle 3: response
        n_tests++;
        if ({cursp_valid, cursp_err, blk_wr_en, sdreq_valid} !== 4'b1010 || req_curSt !== REQ_RSP_CURSP) begin
            n_fail++; $display("FAIL %s_rsp_ctrl: got vld/err/wr/sd=%b st=%0d expected 1010 st=4",
                               nm, {cursp_valid, cursp_err, blk_wr_en, sdreq_valid}, req_curSt);
        end
        n_tests++;
        if (blk_wr_st !== exp_nxt || blk_wr_addr !== addr || req_status !== exp_status) begin
            n_fail++; $display("FAIL %s_rsp_data: got st=%0d addr=%h status=%b expected st=%0d addr=%h status=%b",
                               nm, blk_wr_st, blk_wr_addr, req_status, exp_nxt, addr, exp_status);
        end
        @(posedge clk); #1;
        cursp_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_curSt !== REQ_IDLE || blk_wr_en !== 1'b0 || cursp_valid !== 1'b0 || sdreq_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s_done: got st=%0d wr=%b vld=%b sd=%b expected st=0 wr=0 vld=0 sd=0",
                               nm, req_curSt, blk_wr_en, cursp_valid, sdreq_valid);
        end
        @(posedge clk); #1;
    endtask

    // Transaction through REQ_SDREQ and REQ_WAIT on the main instance.
    task automatic test_sdreq_txn(input string nm, input logic wr, input logic [31:0] addr,
                                  input logic hit, input logic [2:0] blk, input int rdy_dly,
                                  input int rsp_dly, input logic [2:0] rsp, input logic [2:0] exp_op,
                                  input logic [2:0] exp_nxt, input logic [3:0] exp_status);
        cureq_valid = 1'b1; cureq_wr = wr; cureq_addr = addr; cursp_ready = 1'b0;
        @(posedge clk); #1;
        cureq_valid = 1'b0; lkup_hit = hit; lkup_blkSt = blk;
        @(posedge clk); #1;
        lkup_hit = 1'b0; lkup_blkSt = INVALID;
        for (int c = 0; c <= rdy_dly; c++) begin
            sdreq_ready = (c == rdy_dly);
            if (c > 0) corrupt = 1'b1;
            @(negedge clk);
            n_tests++;
            if (sdreq_valid !== 1'b1 || req_curSt !== REQ_SDREQ || sdreq_op !== exp_op) begin
                n_fail++; $display("FAIL %s_sdreq_c%0d: got vld=%b st=%0d op=%0d expected vld=1 st=2 op=%0d",
                                   nm, c, sdreq_valid, req_curSt, sdreq_op, exp_op);
            end
            n_tests++;
            if (sdreq_addr !== addr || req_status !== exp_status || blk_curSt !== blk) begin
                n_fail++; $display("FAIL %s_sdreq_data_c%0d: got addr=%h status=%b blk=%0d expected %h %b %0d",
                                   nm, c, sdreq_addr, req_status, blk_curSt, addr, exp_status, blk);
            end
            @(posedge clk); #1;
        end
        corrupt = 1'b0; sdreq_ready = 1'b0;
        for (int c = 1; c <= rsp_dly; c++) begin
            sursp_valid = (c == rsp_dly);
            sursp_rsp   = (c == rsp_dly) ? rsp : SURSP_NONE;
            @(negedge clk);
            n_tests++;
            if (req_curSt !== REQ_WAIT || cursp_valid !== 1'b0 || sdreq_valid !== 1'b0 || blk_wr_en !== 1'b0) begin
                n_fail++; $display("FAIL %s_wait_c%0d: got st=%0d vld=%b sd=%b wr=%b expected st=3 vld=0 sd=0 wr=0",
                                   nm, c, req_curSt, cursp_valid, sdreq_valid, blk_wr_en);
            end
            @(posedge clk); #1;
        end
        sursp_valid = 1'b0; sursp_rsp = SURSP_NONE;
        @(negedge clk);
        n_tests++;
        if (req_curSt !== REQ_RSP_CURSP || blk_wr_en !== 1'b1 || blk_wr_st !== exp_nxt || sursp_q !== rsp) begin
            n_fail++; $display("FAIL %s_write: got st=%0d wr=%b wst=%0d rsp=%0d expected st=4 wr=1 wst=%0d rsp=%0d",
                               nm, req_curSt, blk_wr_en, blk_wr_st, sursp_q, exp_nxt, rsp);
        end
        n_tests++;
        if (cursp_valid !== 1'b1 || cursp_err !== 1'b0 || blk_wr_addr !== addr) begin
            n_fail++; $display("FAIL %s_rsp: got vld=%b err=%b addr=%h expected vld=1 err=0 addr=%h",
                               nm, cursp_valid, cursp_err, blk_wr_addr, addr);
        end
        @(posedge clk); #1;
        cursp_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (blk_wr_en !== 1'b0 || cursp_valid !== 1'b1 || req_curSt !== REQ_RSP_CURSP) begin
            n_fail++; $display("FAIL %s_hold: got wr=%b vld=%b st=%0d expected wr=0 vld=1 st=4",
                               nm, blk_wr_en, cursp_valid, req_curSt);
        end
        @(posedge clk); #1;
        cursp_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_curSt !== REQ_IDLE || cureq_ready !== 1'b1 || req_status !== 4'b0000) begin
            n_fail++; $display("FAIL %s_idle: got st=%0d rdy=%b status=%b expected st=0 rdy=1 status=0000",
                               nm, req_curSt, cureq_ready, req_status);
        end
        @(posedge clk); #1;
    endtask

    // Read miss on the TIMEOUT_CYC=4 instance; rsp_cyc=0 means no response.
    task automatic test_timeout(input string nm, input int rsp_cyc);
        cureq_valid_t = 1'b1; cureq_wr = 1'b0; cureq_addr = 32'h0000_0A00; cursp_ready = 1'b0;
        @(posedge clk); #1;
        cureq_valid_t = 1'b0; lkup_hit = 1'b0; lkup_blkSt = INVALID;
        @(posedge clk); #1;
        sdreq_ready = 1'b1;
        @(posedge clk); #1;
        sdreq_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            sursp_valid = (c == rsp_cyc);
            sursp_rsp   = (c == rsp_cyc) ? SURSP_FETCH : SURSP_NONE;
            @(negedge clk);
            n_tests++;
            if (t_req_curSt !== REQ_WAIT || t_blk_wr_en !== 1'b0 || t_cursp_valid !== 1'b0) begin
                n_fail++; $display("FAIL %s_wait_c%0d: got st=%0d wr=%b vld=%b expected st=3 wr=0 vld=0",
                                   nm, c, t_req_curSt, t_blk_wr_en, t_cursp_valid);
            end
            @(posedge clk); #1;
        end
        sursp_valid = 1'b0; sursp_rsp = SURSP_NONE;
        @(negedge clk);
        n_tests++;
        if (rsp_cyc == 0) begin
            if (t_req_curSt !== REQ_ERR || {t_cursp_valid, t_cursp_err, t_blk_wr_en} !== 3'b110) begin
                n_fail++; $display("FAIL %s_err: got st=%0d vld/err/wr=%b expected st=5 110",
                                   nm, t_req_curSt, {t_cursp_valid, t_cursp_err, t_blk_wr_en});
            end
        end else begin
            if (t_req_curSt !== REQ_RSP_CURSP || {t_cursp_valid, t_cursp_err, t_blk_wr_en} !== 3'b101 ||
                t_blk_wr_st !== EXCLUSIVE) begin
                n_fail++; $display("FAIL %s_ok: got st=%0d vld/err/wr=%b wst=%0d expected st=4 101 wst=2",
                                   nm, t_req_curSt, {t_cursp_valid, t_cursp_err, t_blk_wr_en}, t_blk_wr_st);
            end
        end
        @(posedge clk); #1;
        cursp_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (t_cursp_valid !== 1'b1 || t_blk_wr_en !== 1'b0 || t_cursp_err !== (rsp_cyc == 0)) begin
            n_fail++; $display("FAIL %s_hold: got vld=%b wr=%b err=%b expected vld=1 wr=0 err=%b",
                               nm, t_cursp_valid, t_blk_wr_en, t_cursp_err, (rsp_cyc == 0));
        end
        @(posedge clk); #1;
        cursp_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (t_req_curSt !== REQ_IDLE || t_cureq_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_idle: got st=%0d rdy=%b expected st=0 rdy=1", nm, t_req_curSt, t_cureq_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_wait();
        cureq_valid = 1'b1; cureq_wr = 1'b0; cureq_addr = 32'h0000_BEE0; cursp_ready = 1'b0;
        @(posedge clk); #1;
        cureq_valid = 1'b0; lkup_hit = 1'b0; lkup_blkSt = INVALID;
        @(posedge clk); #1;
        sdreq_ready = 1'b1;
        @(posedge clk); #1;
        sdreq_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_curSt !== REQ_WAIT) begin
            n_fail++; $display("FAIL rstwait_pre: got st=%0d expected 3", req_curSt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        sursp_valid = 1'b1; sursp_rsp = SURSP_FETCH;
        @(negedge clk);
        n_tests++;
        if ({cureq_ready, req_curSt, sdreq_valid, blk_wr_en, cursp_valid, cursp_err} !== 8'b1_000_0000 ||
            {req_status, blk_curSt, sursp_q, sdreq_op, sdreq_addr} !== 48'h0) begin
            n_fail++; $display("FAIL rstwait_reset: got rdy=%b st=%0d sd=%b vld=%b status=%b addr=%h expected 1 0 0 0 0000 0",
                               cureq_ready, req_curSt, sdreq_valid, cursp_valid, req_status, sdreq_addr);
        end
        @(posedge clk); #1;
        sursp_valid = 1'b0; sursp_rsp = SURSP_NONE;
        @(negedge clk);
        n_tests++;
        if (req_curSt !== REQ_IDLE || sursp_q !== SURSP_NONE || cursp_valid !== 1'b0 || blk_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL rstwait_late_rsp: got st=%0d rsp=%0d vld=%b wr=%b expected 0 0 0 0",
                               req_curSt, sursp_q, cursp_valid, blk_wr_en);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        cureq_valid = 1'b0; cureq_valid_t = 1'b0; cureq_wr = 1'b0; cureq_addr = '0;
        lkup_hit = 1'b0; lkup_blkSt = INVALID; sdreq_ready = 1'b0; sursp_valid = 1'b0;
        sursp_rsp = SURSP_NONE; cursp_ready = 1'b0; corrupt = 1'b0;
        test_reset();
        test_hit("read_hit", 1'b0, 32'h1000_0040, EXCLUSIVE, EXCLUSIVE, 4'b0001);
        test_hit("write_hit_excl", 1'b1, 32'h1000_0080, EXCLUSIVE, MODIFIED, 4'b0010);
        test_sdreq_txn("write_miss", 1'b1, 32'h2000_0100, 1'b0, INVALID, 3, 5,
                       SURSP_FETCH, SDREQ_RFO, MODIFIED, 4'b1000);
        test_sdreq_txn("read_miss_snoop", 1'b0, 32'h3000_0200, 1'b0, INVALID, 0, 2,
                       SURSP_SNOOP, SDREQ_READ, SHARED, 4'b0100);
        test_sdreq_txn("read_miss_fetch", 1'b0, 32'h3000_0240, 1'b0, INVALID, 1, 1,
                       SURSP_FETCH, SDREQ_READ, EXCLUSIVE, 4'b0100);
        test_sdreq_txn("write_hit_shared", 1'b1, 32'h4000_0300, 1'b1, SHARED, 2, 3,
                       SURSP_SNOOP, SDREQ_INV, MODIFIED, 4'b0010);
        test_timeout("timeout", 0);
        test_timeout("rsp_at_expiry", 4);
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/l1_req_seq.md
Name: l1_req_seq

Overview:
Sequencer for one outstanding CPU request at the L1 cache controller. It accepts a CPU request, captures the lookup result, drives the current request state and status vector into fsm_l1_req_ctrl, and issues the downstream snoop request that FSM selects. It then waits for the bus response, commits the next block state, and returns the CPU response. It sits between the CPU port, the tag/state array and the snoop bus interface.

Parameters:
ADDR_W, 32, request address width
TIMEOUT_CYC, 255, maximum cycles in REQ_WAIT before an error response (must be >=1)

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  synchronous active-low reset
cureq_valid  in  1  CPU request valid
cureq_ready  out  1  CPU request accepted when valid&&ready
cureq_wr  in  1  1=write, 0=read
cureq_addr  in  ADDR_W  request address
lkup_hit  in  1  tag hit; valid in REQ_LOOKUP
lkup_blkSt  in  3  block MESI state from the array; valid in REQ_LOOKUP
req_status  out  4  one-hot {WRITE_MISS,READ_MISS,WRITE_HIT,READ_HIT}, index constants from cache_pkg
req_curSt  out  3  current sequencer state, cache_pkg encoding
blk_curSt  out  3  latched block state to the FSM
sursp_q  out  3  latched downstream response to the FSM
fsm_init_sdreq  in  3  downstream request type from the FSM
fsm_blk_nxtSt  in  3  next block state from the FSM
sdreq_valid  out  1  downstream snoop request valid
sdreq_ready  in  1  downstream accept
sdreq_op  out  3  latched fsm_init_sdreq
sdreq_addr  out  ADDR_W  latched request address
sursp_valid  in  1  downstream response valid, single-cycle pulse
sursp_rsp  in  3  SURSP_SNOOP / SURSP_FETCH / other
blk_wr_en  out  1  block-state write strobe
blk_wr_st  out  3  state to write (fsm_blk_nxtSt)
blk_wr_addr  out  ADDR_W  latched address
cursp_valid  out  1  CPU response valid
cursp_ready  in  1  CPU response accepted
cursp_err  out  1  timeout error flag accompanying cursp_valid

Behaviour:
- Reset (rst_n=0 at a clock edge; this also aborts any request in flight): state REQ_IDLE. All outputs 0, except cureq_ready=1 and blk_curSt/sursp_q=INVALID/0. The timeout counter clears.
- REQ_IDLE: cureq_ready=1. On valid&&ready, latch wr and addr, then go to REQ_LOOKUP. A new request cannot be accepted in the same cycle as a response.
- REQ_LOOKUP (1 cycle): latch lkup_hit and lkup_blkSt. From the next cycle, req_status is one-hot from the latched values and held until return to IDLE.
  - Read hit -> REQ_RSP_CURSP.
  - Write hit with blk SHARED -> REQ_SDREQ (invalidate).
  - Write hit otherwise -> REQ_RSP_CURSP.
  - Any miss -> REQ_SDREQ.
- REQ_SDREQ: sdreq_valid=1. sdreq_op is latched from fsm_init_sdreq on the first cycle and held stable until accepted. On sdreq_ready, clear the timeout counter and go to REQ_WAIT.
- REQ_WAIT: counter increments each cycle.
  - sursp_valid: latch sursp_rsp into sursp_q and go to REQ_RSP_CURSP. sursp_valid wins if it occurs on the same cycle as expiry.
  - Counter == TIMEOUT_CYC-1 with no response: go to REQ_ERR.
  - sursp_valid outside REQ_WAIT is ignored.
- REQ_RSP_CURSP:
  - First cycle: blk_wr_en=1 for exactly one cycle, blk_wr_st=fsm_blk_nxtSt. On a read hit the write re-writes the unchanged state, which is harmless.
  - cursp_valid=1, cursp_err=0, held until cursp_ready. cursp_ready on the first cycle is legal; the write still occurs.
  - On accept -> REQ_IDLE.
- REQ_ERR: cursp_valid=1, cursp_err=1, no block write. On cursp_ready -> REQ_IDLE.
- Encodings in cache_pkg: REQ_IDLE=0, REQ_LOOKUP=1, REQ_SDREQ=2, REQ_WAIT=3, REQ_RSP_CURSP=4, REQ_ERR=5. Values 6–7 are illegal and recover to REQ_IDLE.
- Timeout counter width is $clog2(TIMEOUT_CYC+1) and saturates; it never wraps.

Decomposition:
- cache_pkg: req-state typedef/encoding, req_status bit indices, and the SDREQ_*, SURSP_* and MESI constants.
- Sub-module l1_req_timer (load/enable/expire counter) holds the timeout logic.
- fsm_l1_req_ctrl is instantiated alongside in the parent, not inside this block.

Test Plan:
- Read hit, blk EXCLUSIVE, cursp_ready=1 -> no sdreq_valid. blk_wr_en pulse with blk_wr_st=EXCLUSIVE. cursp_valid on cycle 3 after accept, err=0.
- Write miss, sdreq_ready delayed 3 cycles, sursp_rsp=SURSP_FETCH after 5 cycles -> sdreq_op=SDREQ_RFO held stable throughout, blk_wr_st=MODIFIED, one write pulse.
- Read miss with SURSP_SNOOP -> blk_wr_st=SHARED. Repeat with SURSP_FETCH -> EXCLUSIVE.
- Write hit on SHARED -> sdreq_op=SDREQ_INV, then on response blk_wr_st=MODIFIED.
- TIMEOUT_CYC=4, no sursp -> cursp_err=1 after 4 wait cycles, blk_wr_en never asserted. Response at exactly the expiry cycle -> normal completion.
- rst_n low for 1 cycle while in REQ_WAIT -> REQ_IDLE next cycle, all outputs at reset values, cureq_ready=1, a late sursp_valid is ignored.
